// File: rtl/volume_pkg.sv
// Shared types and default constants for the volume control block.
package volume_pkg;

  localparam int VOL_BITS_DEF      = 4;
  localparam int VOL_MAX_DEF       = 15;
  localparam int VOL_DEFAULT_DEF   = 8;
  localparam int HOLD_DELAY_DEF    = 50;
  localparam int REPEAT_PERIOD_DEF = 20;

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    HOLD,
    REPEAT
  } fsm_state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one asynchronous push-button, with a selectable reset level.
module btn_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;

endmodule

// File: rtl/volume_control.sv
// Push-button volume control: saturating level, hold-to-repeat, one-cycle change pulse.
// Optional mute button is enabled by defining VOLUME_CONTROL_MUTE_EN.
module volume_control
  import volume_pkg::*;
#(
  parameter int VOL_BITS      = VOL_BITS_DEF,
  parameter int VOL_MAX       = VOL_MAX_DEF,
  parameter int VOL_DEFAULT   = VOL_DEFAULT_DEF,
  parameter int HOLD_DELAY    = HOLD_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_up,
  input  logic                btn_down,
`ifdef VOLUME_CONTROL_MUTE_EN
  input  logic                btn_mute,
`endif
  output logic [VOL_BITS-1:0] volume,
  output logic                mudou_volume,
  output logic                at_limit
);

  localparam int CNT_MAX = max_int(HOLD_DELAY, REPEAT_PERIOD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [VOL_BITS-1:0] VMAX = VOL_BITS'(VOL_MAX);
  localparam logic [VOL_BITS-1:0] VDEF = VOL_BITS'(VOL_DEFAULT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic AT_LIMIT_RST = (VOL_DEFAULT == 0) || (VOL_DEFAULT == VOL_MAX);

`ifdef VOLUME_CONTROL_MUTE_EN
  localparam int NUM_BTN = 3;
`else
  localparam int NUM_BTN = 2;
`endif

  // Synchronizers reset high so a button held through reset looks "still pressed".
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_s;

`ifdef VOLUME_CONTROL_MUTE_EN
  assign btn_raw = {btn_mute, btn_down, btn_up};
`else
  assign btn_raw = {btn_down, btn_up};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_sync
      btn_sync #(
        .RESET_VAL(1'b1)
      ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(btn_raw[gi]),
        .sync_out(btn_s[gi])
      );
    end
  endgenerate

  logic up_s;
  logic down_s;
  assign up_s   = btn_s[0];
  assign down_s = btn_s[1];

  fsm_state_t state_reg;
  logic [CNT_W-1:0] cnt_reg;
  dir_t dir_reg;

  logic held;
  logic opp;
  assign held = (dir_reg == DIR_UP) ? up_s : down_s;
  assign opp  = (dir_reg == DIR_UP) ? down_s : up_s;

  // Step request decoded from the current state; release and opposite-press veto it.
  logic step_fire;
  logic step_up;

  always_comb begin
    step_fire = 1'b0;
    step_up   = (dir_reg == DIR_UP);
    case (state_reg)
      IDLE: begin
        step_fire = up_s ^ down_s;
        step_up   = up_s;
      end
      HOLD:    step_fire = held && !opp && (cnt_reg == HOLD_LAST);
      REPEAT:  step_fire = held && !opp && (cnt_reg == REP_LAST);
      default: step_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= WAIT_REL;
      cnt_reg   <= '0;
      dir_reg   <= DIR_UP;
    end else begin
      case (state_reg)
        WAIT_REL: begin
          if (!up_s && !down_s) state_reg <= IDLE;
        end
        IDLE: begin
          if (up_s && down_s) begin
            state_reg <= WAIT_REL;
          end else if (up_s || down_s) begin
            cnt_reg   <= '0;
            dir_reg   <= up_s ? DIR_UP : DIR_DOWN;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (!held) begin
            state_reg <= IDLE;
          end else if (opp) begin
            state_reg <= WAIT_REL;
          end else if (cnt_reg == HOLD_LAST) begin
            cnt_reg   <= '0;
            state_reg <= REPEAT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        REPEAT: begin
          if (!held) begin
            state_reg <= IDLE;
          end else if (opp) begin
            state_reg <= WAIT_REL;
          end else if (cnt_reg == REP_LAST) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= WAIT_REL;
      endcase
    end
  end

  logic [VOL_BITS-1:0] level_reg;
  logic [VOL_BITS-1:0] level_next;
  logic [VOL_BITS-1:0] stepped_level;
  logic [VOL_BITS-1:0] display_next;
  logic [VOL_BITS-1:0] volume_reg;
  logic                pulse_next;
  logic                pulse_reg;
  logic                at_limit_reg;

`ifdef VOLUME_CONTROL_MUTE_EN
  logic mute_prev_reg;
  logic mute_rise;
  logic muted_reg;
  logic muted_next;
  assign mute_rise = btn_s[2] & ~mute_prev_reg;
`endif

  // Saturating step: a step at a limit leaves the level where it is.
  always_comb begin
    stepped_level = level_reg;
    if (step_up && (level_reg < VMAX)) begin
      stepped_level = level_reg + 1'b1;
    end else if (!step_up && (level_reg != '0)) begin
      stepped_level = level_reg - 1'b1;
    end
  end

  always_comb begin
    level_next = level_reg;
    pulse_next = 1'b0;
`ifdef VOLUME_CONTROL_MUTE_EN
    muted_next = muted_reg;
    if (step_fire) begin
      level_next = stepped_level;
      pulse_next = (stepped_level != level_reg) || muted_reg;
      muted_next = 1'b0;
    end else if (mute_rise) begin
      muted_next = ~muted_reg;
      pulse_next = 1'b1;
    end
    display_next = muted_next ? '0 : level_next;
`else
    if (step_fire) begin
      level_next = stepped_level;
      pulse_next = (stepped_level != level_reg);
    end
    display_next = level_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg    <= VDEF;
      volume_reg   <= VDEF;
      pulse_reg    <= 1'b0;
      at_limit_reg <= AT_LIMIT_RST;
`ifdef VOLUME_CONTROL_MUTE_EN
      mute_prev_reg <= 1'b1;
      muted_reg     <= 1'b0;
`endif
    end else begin
      level_reg    <= level_next;
      volume_reg   <= display_next;
      pulse_reg    <= pulse_next;
      at_limit_reg <= (display_next == '0) || (display_next == VMAX);
`ifdef VOLUME_CONTROL_MUTE_EN
      mute_prev_reg <= btn_s[2];
      muted_reg     <= muted_next;
`endif
    end
  end

  assign volume       = volume_reg;
  assign mudou_volume = pulse_reg;
  assign at_limit     = at_limit_reg;

endmodule
